// File: rtl/node_relax_scheduler.sv
// ---------------------------------------------------------------------------
// node_relax_scheduler
//
// Sequences an iterative relaxation of a node-voltage network. Each sweep
// visits every node once: read its voltage from an external RAM, add the
// summed current flowing into it (with saturation), and write the result
// back. A sweep in which every node's current stayed within +/-THRESH counts
// as converged; otherwise another sweep follows, up to MAX_SWEEPS.
//
// Ports
//   clk          sole clock, rising edge
//   rst_n        asynchronous active-low reset
//   start        single-cycle run request (honoured only when idle)
//   busy         high while a run is in progress
//   done         one-cycle pulse when a run ends
//   timeout      valid with done: 1 = sweep limit hit, 0 = converged
//   node_addr    node currently processed (voltage RAM and current summer)
//   v_rd_en      voltage RAM read strobe, data returns next cycle
//   v_rd_data    node voltage, valid the cycle after v_rd_en
//   i_sum        summed current into node_addr, valid the cycle after v_rd_en
//   v_wr_en      voltage RAM write strobe at node_addr
//   v_wr_data    updated node voltage
//   sweep_count  completed sweeps in the current/last run
// ---------------------------------------------------------------------------
module node_relax_scheduler #(
  parameter int W          = 16,
  parameter int N_NODES    = 64,
  parameter int AW         = 6,
  parameter int THRESH     = 2,
  parameter int MAX_SWEEPS = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout,
  output logic [AW-1:0]        node_addr,
  output logic                 v_rd_en,
  input  logic signed [W-1:0]  v_rd_data,
  input  logic signed [W-1:0]  i_sum,
  output logic                 v_wr_en,
  output logic signed [W-1:0]  v_wr_data,
  output logic [7:0]           sweep_count
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    ACC,
    WRITE,
    CHECK
  } state_t;

  localparam logic [AW-1:0]       LAST_ADDR  = AW'(N_NODES - 1);
  localparam logic [AW-1:0]       ADDR_ONE   = AW'(1);
  localparam logic [W:0]          EXT_ONE    = (W+1)'(1);
  localparam logic [W:0]          THRESH_EXT = (W+1)'(THRESH);
  localparam logic [7:0]          MAX_CNT    = 8'(MAX_SWEEPS);
  localparam logic signed [W-1:0] V_MAX      = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] V_MIN      = {1'b1, {(W-1){1'b0}}};

  state_t                state, state_next;
  logic                  quiet, quiet_next;
  logic [AW-1:0]         addr_next;
  logic [7:0]            count_next;
  logic                  done_next;
  logic                  timeout_next;
  logic signed [W-1:0]   wr_data_next;

  // Datapath for the ACC step: one extra bit of headroom detects overflow,
  // which shows up as the two top bits of the sum disagreeing.
  logic [W:0]            v_ext, i_ext, sum_ext, i_mag;
  logic signed [W-1:0]   v_sat;
  logic                  loud;
  logic [7:0]            count_inc;

  always_comb begin
    v_ext   = {v_rd_data[W-1], v_rd_data};
    i_ext   = {i_sum[W-1], i_sum};
    sum_ext = v_ext + i_ext;
    if (sum_ext[W] != sum_ext[W-1]) begin
      v_sat = sum_ext[W] ? V_MIN : V_MAX;
    end else begin
      v_sat = sum_ext[W-1:0];
    end
    // Magnitude at W+1 bits so the most negative current maps to 2^(W-1)
    // instead of wrapping back onto itself.
    i_mag = i_sum[W-1] ? (~i_ext + EXT_ONE) : i_ext;
    loud  = (i_mag > THRESH_EXT);
  end

  assign count_inc = (sweep_count == 8'hFF) ? 8'hFF : sweep_count + 8'd1;
  assign busy      = (state != IDLE);

  // NOTE: every signal assigned here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_next   = state;
    addr_next    = node_addr;
    quiet_next   = quiet;
    count_next   = sweep_count;
    done_next    = 1'b0;
    timeout_next = timeout;
    wr_data_next = v_wr_data;
    v_rd_en      = 1'b0;
    v_wr_en      = 1'b0;

    case (state)
      IDLE: begin
        // done is still high in the first idle cycle; a start arriving with
        // it belongs to the run that just ended and is dropped.
        if (start && !done) begin
          state_next   = READ;
          addr_next    = '0;
          quiet_next   = 1'b1;
          count_next   = 8'd0;
          timeout_next = 1'b0;
        end
      end
      READ: begin
        v_rd_en    = 1'b1;
        state_next = ACC;
      end
      ACC: begin
        wr_data_next = v_sat;
        if (loud) quiet_next = 1'b0;
        state_next   = WRITE;
      end
      WRITE: begin
        v_wr_en = 1'b1;
        if (node_addr == LAST_ADDR) begin
          state_next = CHECK;
        end else begin
          addr_next  = node_addr + ADDR_ONE;
          state_next = READ;
        end
      end
      CHECK: begin
        count_next = count_inc;
        if (quiet) begin
          done_next    = 1'b1;
          timeout_next = 1'b0;
          state_next   = IDLE;
        end else if (count_inc == MAX_CNT) begin
          done_next    = 1'b1;
          timeout_next = 1'b1;
          state_next   = IDLE;
        end else begin
          addr_next  = '0;
          quiet_next = 1'b1;
          state_next = READ;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the values from before this edge, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      node_addr   <= '0;
      quiet       <= 1'b1;
      sweep_count <= 8'd0;
      done        <= 1'b0;
      timeout     <= 1'b0;
      v_wr_data   <= '0;
    end else begin
      state       <= state_next;
      node_addr   <= addr_next;
      quiet       <= quiet_next;
      sweep_count <= count_next;
      done        <= done_next;
      timeout     <= timeout_next;
      v_wr_data   <= wr_data_next;
    end
  end

endmodule

// File: tb/tb_node_relax_scheduler.sv
// ---------------------------------------------------------------------------
// tb_node_relax_scheduler
//
// Drives node_relax_scheduler (N_NODES=4, THRESH=2, MAX_SWEEPS=5) against a
// small voltage RAM and a current source whose pattern depends on the mode
// of each run. A run-level model predicts, cycle by cycle, which strobes,
// addresses and write data must appear; a compare process checks the DUT
// against it every cycle of a run. Literal values pin the model and the
// run outcomes.
// ---------------------------------------------------------------------------
module tb_node_relax_scheduler;

  localparam int W    = 16;
  localparam int N    = 4;
  localparam int AW   = 2;
  localparam int TH   = 2;
  localparam int MAXS = 5;
  localparam int MAXC = 96;

  logic                clk = 1'b0;
  logic                rst_n, start;
  logic                busy, done, timeout;
  logic [AW-1:0]       node_addr;
  logic                v_rd_en, v_wr_en;
  logic signed [W-1:0] v_rd_data, i_sum, v_wr_data;
  logic [7:0]          sweep_count;

  always #5 clk = ~clk;

  node_relax_scheduler #(
    .W(W), .N_NODES(N), .AW(AW), .THRESH(TH), .MAX_SWEEPS(MAXS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .timeout(timeout), .node_addr(node_addr), .v_rd_en(v_rd_en),
    .v_rd_data(v_rd_data), .i_sum(i_sum), .v_wr_en(v_wr_en),
    .v_wr_data(v_wr_data), .sweep_count(sweep_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Current pattern per mode, by sweep index s and node n.
  function automatic logic signed [15:0] isum_fn(input int m, input int s, input int n);
    int r;
    r = 0;
    case (m)
      1: r = (s == 0 && n == 2) ? 100 : 0;
      2: r = (n == 0) ? 3 : 0;
      3: r = (s == 0) ? ((n == 0) ? 256 : (n == 1) ? -256 : 0) : 0;
      4: r = (s == 0 && n == 3) ? -32768 : 0;
      5: r = (n % 2 == 1) ? -2 : 2;
      6: r = 5;
      default: r = 0;
    endcase
    return 16'(r);
  endfunction

  function automatic int sat(input int x);
    if (x > 32767) return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  // ---------------- environment: voltage RAM + current source ------------
  logic signed [W-1:0] ram      [N];
  logic signed [W-1:0] init_ram [N];
  int                  mode = 0;
  logic                clr_req = 1'b0;
  int                  rd_cnt = 0, rd_node_q = 0, rd_sweep_q = 0;
  logic [AW-1:0]       rd_addr_q = '0;
  int                  edges = 0, run_edge = 0;

  always @(posedge clk) edges <= edges + 1;

  always @(posedge clk) begin
    if (clr_req) begin
      rd_cnt <= 0;
      for (int k = 0; k < N; k++) ram[k] <= init_ram[k];
    end else begin
      if (v_rd_en) begin
        rd_addr_q  <= node_addr;
        rd_node_q  <= rd_cnt % N;
        rd_sweep_q <= rd_cnt / N;
        rd_cnt     <= rd_cnt + 1;
      end
      if (v_wr_en) ram[node_addr] <= v_wr_data;
    end
  end

  assign v_rd_data = ram[rd_addr_q];
  assign i_sum     = isum_fn(mode, rd_sweep_q, rd_node_q);

  // ---------------- run model --------------------------------------------
  logic exp_rd [MAXC], exp_wr [MAXC], exp_busy [MAXC], exp_done [MAXC];
  int   exp_addr [MAXC], exp_data [MAXC];
  int   exp_len, exp_timeout, exp_count;

  task automatic build_model(input int m);
    int vm [N];
    int c, cnt, v, is;
    bit quiet;
    for (int k = 0; k < MAXC; k++) begin
      exp_rd[k] = 0; exp_wr[k] = 0; exp_busy[k] = 0; exp_done[k] = 0;
      exp_addr[k] = 0; exp_data[k] = 0;
    end
    for (int k = 0; k < N; k++) vm[k] = init_ram[k];
    c = 1; cnt = 0; exp_len = 0; exp_timeout = 0; exp_count = 0;
    for (int s = 0; s < 300; s++) begin
      quiet = 1;
      for (int n = 0; n < N; n++) begin
        is    = isum_fn(m, s, n);
        v     = sat(vm[n] + is);
        vm[n] = v;
        if (is > TH || is < -TH) quiet = 0;
        exp_rd[c] = 1;     exp_addr[c] = n;
        exp_busy[c] = 1;   exp_busy[c+1] = 1; exp_busy[c+2] = 1;
        exp_wr[c+2] = 1;   exp_addr[c+2] = n; exp_data[c+2] = v;
        c += 3;
      end
      exp_busy[c] = 1;
      c++;
      cnt = (cnt < 255) ? cnt + 1 : 255;
      if (quiet || cnt == MAXS) begin
        exp_done[c] = 1;
        exp_len     = c;
        exp_timeout = quiet ? 0 : 1;
        exp_count   = cnt;
        break;
      end
    end
  endtask

  // ---------------- compare process --------------------------------------
  logic chk_en = 1'b0;

  always @(negedge clk) begin
    int c;
    if (chk_en) begin
      c = edges - run_edge;
      if (c >= 1 && c <= exp_len) begin
        check($sformatf("c%0d busy", c), busy, exp_busy[c]);
        check($sformatf("c%0d done", c), done, exp_done[c]);
        check($sformatf("c%0d v_rd_en", c), v_rd_en, exp_rd[c]);
        check($sformatf("c%0d v_wr_en", c), v_wr_en, exp_wr[c]);
        if (exp_rd[c] || exp_wr[c])
          check($sformatf("c%0d node_addr", c), node_addr, exp_addr[c]);
        if (exp_wr[c])
          check($sformatf("c%0d v_wr_data", c), v_wr_data, exp_data[c]);
        if (exp_done[c]) begin
          check($sformatf("c%0d timeout", c), timeout, exp_timeout);
          check($sformatf("c%0d sweep_count", c), sweep_count, exp_count);
        end
      end
    end
  end

  // ---------------- stimulus helpers -------------------------------------
  task automatic set_ram(input int a, input int b, input int c, input int d);
    init_ram[0] = 16'(a); init_ram[1] = 16'(b);
    init_ram[2] = 16'(c); init_ram[3] = 16'(d);
  endtask

  task automatic launch(input int m);
    mode = m;
    build_model(m);
    @(negedge clk);
    start = 1'b1; clr_req = 1'b1; run_edge = edges;
    @(posedge clk); #1;
    start = 1'b0; clr_req = 1'b0; chk_en = 1'b1;
  endtask

  // Returns the cycle (relative to the start cycle) in which done was seen,
  // or -1 if it never came within the budget.
  task automatic wait_done(output int dc);
    dc = -1;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      if (done) begin
        dc = edges - run_edge;
        break;
      end
    end
  endtask

  task automatic finish_run();
    @(posedge clk); #1;
    chk_en = 1'b0;
  endtask

  task automatic run_test(input string name, input int m, input int lit_len,
                          input int lit_to, input int lit_cnt);
    int dc;
    launch(m);
    check({name, " model_len"}, exp_len, lit_len);
    wait_done(dc);
    check({name, " done_cycle"}, dc, lit_len);
    check({name, " timeout"}, timeout, lit_to);
    check({name, " sweep_count"}, sweep_count, lit_cnt);
    finish_run();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check({name, " idle_busy"}, busy, 0);
      check({name, " idle_done"}, done, 0);
      check({name, " hold_timeout"}, timeout, lit_to);
      check({name, " hold_count"}, sweep_count, lit_cnt);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, " busy"}, busy, 0);
    check({name, " done"}, done, 0);
    check({name, " timeout"}, timeout, 0);
    check({name, " v_rd_en"}, v_rd_en, 0);
    check({name, " v_wr_en"}, v_wr_en, 0);
    check({name, " v_wr_data"}, v_wr_data, 0);
    check({name, " node_addr"}, node_addr, 0);
    check({name, " sweep_count"}, sweep_count, 0);
  endtask

  // ---------------- main sequence ----------------------------------------
  initial begin
    int dc, wr_seen, busy_seen;
    rst_n = 1'b0;
    start = 1'b0;
    set_ram(100, -200, 300, -400);
    #1;
    check_reset_outputs("reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // all currents zero: one sweep, converged
    run_test("quiet", 0, 14, 0, 1);
    // one loud node in sweep 1 only
    run_test("one_loud", 1, 27, 0, 2);
    // current of 3 on node 0 forever: just above threshold, times out
    run_test("timeout", 2, 66, 1, 5);
    // currents of exactly +/-THRESH count as quiet
    run_test("at_thresh", 5, 14, 0, 1);
    // most negative current is loud
    run_test("min_isum", 4, 27, 0, 2);

    // saturation at both rails
    set_ram(16'h7FF0, 16'h8010, 7, -7);
    run_test("saturate", 3, 27, 0, 2);
    check("sat_pos ram0", ram[0], 32767);
    check("sat_neg ram1", ram[1], -32768);

    // start while busy and coincident with done is ignored
    set_ram(100, -200, 300, -400);
    launch(0);
    repeat (4) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(dc);
    check("ignore_start done_cycle", dc, 14);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("ignore_start busy", busy, 0);
      check("ignore_start v_rd_en", v_rd_en, 0);
      check("ignore_start sweep_count", sweep_count, 1);
    end

    // reset during the WRITE of node 1
    launch(6);
    dc = -1;
    for (int k = 0; k < 20; k++) begin
      if (edges - run_edge == 6) begin
        dc = 6;
        break;
      end
      @(posedge clk); #1;
    end
    check("abort reached_write", dc, 6);
    check("abort pre_wr_en", v_wr_en, 1);
    check("abort pre_addr", node_addr, 1);
    chk_en = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("abort_async");
    @(posedge clk); #1;
    check_reset_outputs("abort_edge");
    @(negedge clk);
    rst_n = 1'b1;
    wr_seen = 0; busy_seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (v_wr_en) wr_seen++;
      if (busy) busy_seen++;
    end
    check("abort no_writes", wr_seen, 0);
    check("abort stays_idle", busy_seen, 0);
    check("abort ram0_written", ram[0], 105);
    check("abort ram1_untouched", ram[1], -200);

    // normal run after the abort
    run_test("after_abort", 0, 14, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
